// File: rtl/ac_motor_gate_guard_pkg.sv
// Shared definitions for the inverter gate guard: FSM state encodings and fault_src bit indices.
// Ports: none (package).
// Imported by ac_motor_gate_guard.
package ac_motor_gate_guard_pkg;

  typedef enum logic [1:0] {
    AC_MOTOR_GG_IDLE    = 2'd0,
    AC_MOTOR_GG_RUN     = 2'd1,
    AC_MOTOR_GG_FAULT   = 2'd2,
    AC_MOTOR_GG_HOLDOFF = 2'd3
  } state_e;

  // fault_src bit positions
  localparam int FSRC_PH1  = 0;
  localparam int FSRC_PH2  = 1;
  localparam int FSRC_PH3  = 2;
  localparam int FSRC_TRIP = 3;
  localparam int FSRC_W    = 4;

endpackage

// File: rtl/ac_motor_gate_filter.sv
// Per-phase gate filter: min-pulse qualification of high/low switch commands, registered outputs.
// Ports: clk, reset (sync, active-high), run (block is/will be in RUN), high_in/low_in -> high/low.
// Macro AC_MOTOR_GATE_GUARD_MIN_PULSE_EN: defined = rising edges delayed MIN_PULSE clocks; undefined = plain 1-clock register.
module ac_motor_gate_filter #(
  parameter int MIN_PULSE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic high_in,
  input  logic low_in,
  output logic high,
  output logic low
);

  logic high_q, high_d;
  logic low_q, low_d;

`ifdef AC_MOTOR_GATE_GUARD_MIN_PULSE_EN
  localparam logic [7:0] MP8 = 8'(MIN_PULSE);

  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] lcnt_q, lcnt_d;

  // Counts consecutive on-clocks, saturating at MIN_PULSE; any off clock or
  // leaving RUN restarts qualification from zero.
  function automatic logic [7:0] next_cnt(input logic active, input logic [7:0] cnt);
    logic [7:0] r;
    r = 8'd0;
    if (active) begin
      r = (cnt >= MP8) ? MP8 : cnt + 8'd1;
    end
    return r;
  endfunction

  always_comb begin
    hcnt_d = next_cnt(run && high_in, hcnt_q);
    lcnt_d = next_cnt(run && low_in, lcnt_q);
    // Turn-on waits for a full qualified count; turn-off is immediate because
    // the input term drops the same clock. The opposite-input term keeps the
    // pair mutually exclusive even for the single clock a shoot-through is seen.
    high_d = run && high_in && !low_in && (hcnt_d == MP8);
    low_d  = run && low_in && !high_in && (lcnt_d == MP8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= 8'd0;
      lcnt_q <= 8'd0;
    end else begin
      hcnt_q <= hcnt_d;
      lcnt_q <= lcnt_d;
    end
  end
`else
  always_comb begin
    high_d = run && high_in && !low_in;
    low_d  = run && low_in && !high_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= 1'b0;
      low_q  <= 1'b0;
    end else begin
      high_q <= high_d;
      low_q  <= low_d;
    end
  end

  assign high = high_q;
  assign low  = low_q;

  param_range: assert property (@(posedge clk) (MIN_PULSE >= 1) && (MIN_PULSE <= 255));
  no_shoot_through: assert property (@(posedge clk) disable iff (reset) !(high_q && low_q));

endmodule

// File: rtl/ac_motor_gate_guard.sv
// Gate guard between dead-time stages and gate-driver pins: min-pulse filter, shoot-through/trip fault latch, hold-off release.
// Ports: clk, reset (sync, active-high), enable, fault_clear, trip (async); s{1,2,3}_{high,low}_in -> s{1,2,3}_{high,low};
//        fault, fault_src[3:0] (bit0-2 shoot-through ph1-3, bit3 trip), running. Macro: AC_MOTOR_GATE_GUARD_MIN_PULSE_EN.
module ac_motor_gate_guard
  import ac_motor_gate_guard_pkg::*;
#(
  parameter int MIN_PULSE = 8,
  parameter int HOLDOFF   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fault_clear,
  input  logic              trip,
  input  logic              s1_high_in,
  input  logic              s1_low_in,
  input  logic              s2_high_in,
  input  logic              s2_low_in,
  input  logic              s3_high_in,
  input  logic              s3_low_in,
  output logic              s1_high,
  output logic              s1_low,
  output logic              s2_high,
  output logic              s2_low,
  output logic              s3_high,
  output logic              s3_low,
  output logic              fault,
  output logic [FSRC_W-1:0] fault_src,
  output logic              running
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

  state_e state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [FSRC_W-1:0] src_q, src_d;
  logic trip_meta_q, trip_sync_q;

  logic [FSRC_W-1:0] cause;
  logic shoot_any;
  logic fault_cond;
  logic run_next;

  // Two-flop synchronizer for the asynchronous trip input.
  always_ff @(posedge clk) begin
    if (reset) begin
      trip_meta_q <= 1'b0;
      trip_sync_q <= 1'b0;
    end else begin
      trip_meta_q <= trip;
      trip_sync_q <= trip_meta_q;
    end
  end

  always_comb begin
    cause            = '0;
    cause[FSRC_PH1]  = s1_high_in && s1_low_in;
    cause[FSRC_PH2]  = s2_high_in && s2_low_in;
    cause[FSRC_PH3]  = s3_high_in && s3_low_in;
    cause[FSRC_TRIP] = trip_sync_q;
    shoot_any        = cause[FSRC_PH1] || cause[FSRC_PH2] || cause[FSRC_PH3];
    fault_cond       = |cause;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AC_MOTOR_GG_IDLE: begin
        if (fault_cond)  state_d = AC_MOTOR_GG_FAULT;
        else if (enable) state_d = AC_MOTOR_GG_RUN;
      end
      AC_MOTOR_GG_RUN: begin
        if (fault_cond)   state_d = AC_MOTOR_GG_FAULT;
        else if (!enable) state_d = AC_MOTOR_GG_IDLE;
      end
      AC_MOTOR_GG_FAULT: begin
        // Release only once the operator acknowledges and every cause is gone.
        if (fault_clear && !trip_sync_q && !shoot_any) state_d = AC_MOTOR_GG_HOLDOFF;
      end
      AC_MOTOR_GG_HOLDOFF: begin
        if (fault_cond) state_d = AC_MOTOR_GG_FAULT;
        else if (hold_cnt_q == HOLD_LAST) state_d = enable ? AC_MOTOR_GG_RUN : AC_MOTOR_GG_IDLE;
      end
      default: state_d = AC_MOTOR_GG_IDLE;
    endcase
  end

  always_comb begin
    // Counter only advances while staying in HOLDOFF, so any re-entry starts at 0.
    hold_cnt_d = '0;
    if (state_q == AC_MOTOR_GG_HOLDOFF && state_d == AC_MOTOR_GG_HOLDOFF) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end

    src_d = src_q;
    if (state_q != AC_MOTOR_GG_FAULT && state_d == AC_MOTOR_GG_FAULT) begin
      src_d = src_q | cause;
    end else if (state_q == AC_MOTOR_GG_FAULT && state_d == AC_MOTOR_GG_HOLDOFF) begin
      src_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AC_MOTOR_GG_IDLE;
      hold_cnt_q <= '0;
      src_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      src_q      <= src_d;
    end
  end

  // Filters look at the next state so gate registers drop on the very edge the
  // FSM leaves RUN (fault, disable), not one clock later.
  assign run_next = (state_d == AC_MOTOR_GG_RUN);

  ac_motor_gate_filter #(.MIN_PULSE(MIN_PULSE)) u_ph1 (
    .clk(clk), .reset(reset), .run(run_next),
    .high_in(s1_high_in), .low_in(s1_low_in),
    .high(s1_high), .low(s1_low)
  );

  ac_motor_gate_filter #(.MIN_PULSE(MIN_PULSE)) u_ph2 (
    .clk(clk), .reset(reset), .run(run_next),
    .high_in(s2_high_in), .low_in(s2_low_in),
    .high(s2_high), .low(s2_low)
  );

  ac_motor_gate_filter #(.MIN_PULSE(MIN_PULSE)) u_ph3 (
    .clk(clk), .reset(reset), .run(run_next),
    .high_in(s3_high_in), .low_in(s3_low_in),
    .high(s3_high), .low(s3_low)
  );

  assign fault     = (state_q == AC_MOTOR_GG_FAULT);
  assign running   = (state_q == AC_MOTOR_GG_RUN);
  assign fault_src = src_q;

  holdoff_range: assert property (@(posedge clk) (HOLDOFF >= 1) && (HOLDOFF <= 65535));

endmodule
